hilo_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs a 32-iteration shift-add multiply or restoring divide.
- Drives HI/LO write data and enables, and holds the pipeline via busy.
- Controller runs on posedge clk; registered outputs are stable for the full WRITE cycle, so a falling-edge HI/LO register captures them mid-cycle.

---
 rtl/hilo_muldiv_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Define HILO_FAST_MUL_EN to compute MULT/MULTU in a single cycle instead.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             hi_we,
    output logic             lo_we,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_WRITE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg_q;
    logic               rneg_q;

    logic               is_mul_op;
    logic               is_div_op;
    logic               is_mt_op;
    logic               is_signed_op;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] mul_res;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign_w(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic neg, input logic [2*WIDTH-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // One shift-add step: {hi, lo} holds the partial product above the unconsumed multiplier bits.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] prod,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, prod[WIDTH-1:1]};
    endfunction

    // One restoring step: hi is the running remainder, lo shifts dividend bits out and quotient bits in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] sh;
        logic           ge;
        sh = {rem, quo[WIDTH-1]};
        ge = (sh >= {1'b0, dvs});
        if (ge) begin
            sh = sh - {1'b0, dvs};
        end
        return {sh[WIDTH-1:0], quo[WIDTH-2:0], ge};
    endfunction

    assign is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_mt_op     = (op == OP_MTHI) || (op == OP_MTLO);
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign rs_mag       = magnitude(rs_val, is_signed_op);
    assign rt_mag       = magnitude(rt_val, is_signed_op);

    // flush wins over a simultaneous start; illegal opcodes are simply not accepted
    assign accept    = (state == S_IDLE) && start && !flush && (is_mul_op || is_div_op || is_mt_op);
    assign last_iter = (cnt == LAST_CNT);
    assign busy      = (state != S_IDLE);

    assign mul_nxt = mul_step({acc_hi, acc_lo}, opnd_b);
    assign mul_res = apply_sign_2w(neg_q, mul_nxt);
    assign div_nxt = div_step(acc_hi, acc_lo, opnd_b);
    assign quo_res = apply_sign_w(neg_q, div_nxt[WIDTH-1:0]);
    assign rem_res = apply_sign_w(rneg_q, div_nxt[2*WIDTH-1:WIDTH]);

`ifdef HILO_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = apply_sign_2w(is_signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]),
                                     {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
`ifdef HILO_FAST_MUL_EN
                        state_n = S_WRITE;
`else
                        state_n = S_MUL;
`endif
                    end else if (is_div_op && (rt_val != '0)) begin
                        state_n = S_DIV;
                    end else begin
                        state_n = S_WRITE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (last_iter) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Write strobes are registered on entry to WRITE so they are stable across the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            opnd_b      <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            hi_wdata    <= '0;
            lo_wdata    <= '0;
            hi_we       <= 1'b0;
            lo_we       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            hi_we       <= 1'b0;
            lo_we       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                acc_hi <= '0;
                if (is_mul_op) begin
                    opnd_b <= rs_mag;
                    acc_lo <= rt_mag;
                    neg_q  <= is_signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    rneg_q <= 1'b0;
`ifdef HILO_FAST_MUL_EN
                    hi_wdata <= fast_prod[2*WIDTH-1:WIDTH];
                    lo_wdata <= fast_prod[WIDTH-1:0];
                    hi_we    <= 1'b1;
                    lo_we    <= 1'b1;
                    done     <= 1'b1;
`endif
                end else if (is_div_op) begin
                    opnd_b <= rt_mag;
                    acc_lo <= rs_mag;
                    neg_q  <= is_signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    rneg_q <= is_signed_op & rs_val[WIDTH-1];
                    if (rt_val == '0) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end else begin
                    done <= 1'b1;
                    if (op == OP_MTHI) begin
                        hi_wdata <= rs_val;
                        hi_we    <= 1'b1;
                    end else begin
                        lo_wdata <= rs_val;
                        lo_we    <= 1'b1;
                    end
                end
            end else if ((state == S_MUL) && !flush) begin
                {acc_hi, acc_lo} <= mul_nxt;
                cnt              <= cnt + 1'b1;
                if (last_iter) begin
                    hi_wdata <= mul_res[2*WIDTH-1:WIDTH];
                    lo_wdata <= mul_res[WIDTH-1:0];
                    hi_we    <= 1'b1;
                    lo_we    <= 1'b1;
                    done     <= 1'b1;
                end
            end else if ((state == S_DIV) && !flush) begin
                {acc_hi, acc_lo} <= div_nxt;
                cnt              <= cnt + 1'b1;
                if (last_iter) begin
                    hi_wdata <= rem_res;
                    lo_wdata <= quo_res;
                    hi_we    <= 1'b1;
                    lo_we    <= 1'b1;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed and random operations against
// an arithmetic reference model of the HI/LO results and completion timing.
module tb_hilo_muldiv_ctrl;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic        lo_we;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    // last values the model expects on hi_wdata / lo_wdata (they hold outside WRITE)
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .flush(flush),
        .busy(busy),
        .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_hi_we"}, hi_we, 0);
        check({tag, "_lo_we"}, lo_we, 0);
        check({tag, "_dbz"}, div_by_zero, 0);
        check({tag, "_hi_wdata"}, hi_wdata, mdl_hi);
        check({tag, "_lo_wdata"}, lo_wdata, mdl_lo);
    endtask

    // Issue one operation, wait for done, compare against the model; inj > 0 pulses
    // a competing MTHI start in that cycle of the operation, which must be ignored.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [31:0] e_hi, e_lo;
        logic        e_hwe, e_lwe, e_dbz;
        int          e_lat, cyc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_hi = mdl_hi; e_lo = mdl_lo;
        e_hwe = 1'b0; e_lwe = 1'b0; e_dbz = 1'b0; e_lat = 1;
        case (o)
            3'b000: begin
                p = sa * sb;
                e_hi = p[63:32]; e_lo = p[31:0]; e_hwe = 1'b1; e_lwe = 1'b1; e_lat = MUL_LAT;
            end
            3'b001: begin
                p = {32'b0, a} * {32'b0, b};
                e_hi = p[63:32]; e_lo = p[31:0]; e_hwe = 1'b1; e_lwe = 1'b1; e_lat = MUL_LAT;
            end
            3'b010: begin
                if (b == 0) e_dbz = 1'b1;
                else begin
                    q = sa / sb; r = sa % sb;
                    e_lo = 32'(q); e_hi = 32'(r); e_hwe = 1'b1; e_lwe = 1'b1; e_lat = DIV_LAT;
                end
            end
            3'b011: begin
                if (b == 0) e_dbz = 1'b1;
                else begin
                    e_lo = a / b; e_hi = a % b; e_hwe = 1'b1; e_lwe = 1'b1; e_lat = DIV_LAT;
                end
            end
            3'b100: begin e_hi = a; e_hwe = 1'b1; end
            default: begin e_lo = a; e_lwe = 1'b1; end
        endcase

        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            check("busy_during_op", busy, 1);
            @(negedge clk);
            cyc++;
            start = (inj > 0 && cyc == inj);
            if (start) begin
                op = 3'b100; rs_val = 32'hDEADBEEF;
            end
        end
        start = 1'b0;
        check("done_latency", cyc, e_lat);
        check("write_busy", busy, 1);
        check("write_hi_we", hi_we, e_hwe);
        check("write_lo_we", lo_we, e_lwe);
        check("write_dbz", div_by_zero, e_dbz);
        check("write_hi_wdata", hi_wdata, e_hi);
        check("write_lo_wdata", lo_wdata, e_lo);
        mdl_hi = e_hi;
        mdl_lo = e_lo;
        @(negedge clk);
        check_idle_outputs("after_write");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        saw_done;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        run_op(3'b000, 32'hFFFFFFFE, 32'd3, 0);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0);
        run_op(3'b011, 32'd100, 32'd7, 0);
        run_op(3'b011, 32'd55, 32'd0, 0);
        run_op(3'b101, 32'h1234, 32'd0, 0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(3'b010, 32'd7, 32'hFFFFFFFE, 0);
        run_op(3'b000, 32'h80000000, 32'h80000000, 0);
        run_op(3'b100, 32'hCAFEF00D, 32'd9, 0);

        // a start arriving while busy is dropped, not queued
        run_op(3'b011, 32'd1000, 32'd7, 5);
        @(negedge clk);
        check_idle_outputs("no_queued_op");

        // flush during DIV at cycle 10 returns to IDLE at cycle 11 without any write
        @(negedge clk);
        start = 1'b1; op = 3'b010; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle_outputs("flush_cycle11");
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || hi_we === 1'b1 || lo_we === 1'b1) saw_done = 1'b1;
        end
        check("flush_no_write", saw_done, 0);

        // flush in IDLE beats a simultaneous start
        start = 1'b1; flush = 1'b1; op = 3'b100; rs_val = 32'h5555AAAA;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_idle_outputs("flush_idle_start");
        @(negedge clk);
        check_idle_outputs("flush_idle_start_next");

        // illegal opcode is not accepted
        start = 1'b1; op = 3'b110; rs_val = 32'h77777777;
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs("illegal_op");
        @(negedge clk);
        check_idle_outputs("illegal_op_next");

        // asynchronous reset at cycle 20 of MULT clears everything immediately
        start = 1'b1; op = 3'b000; rs_val = 32'h12345678; rt_val = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_hi = '0;
        mdl_lo = '0;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
        run_op(3'b100, 32'h0BADCAFE, 32'd0, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 16));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(ro, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
